// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB3 initiator, one-entry pending buffer for back-to-back transfers.
// Optional PREADY timeout compiled in with `define APB_MASTER_TIMEOUT_EN (uses TIMEOUT_CYCLES).
//   state     | meaning
//   ST_IDLE   | bus idle, PSEL=0
//   ST_SETUP  | PSEL=1 PENABLE=0, one cycle
//   ST_ACCESS | PSEL=1 PENABLE=1, wait for PREADY (or timeout)
module apb_master_bridge #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]                 state;
    logic                       pend_full;
    logic                       pend_write;
    logic [AMBA_ADDR_WIDTH-1:0] pend_addr;
    logic [AMBA_WORD-1:0]       pend_wdata;
    logic                       accept;
    logic                       abort;
    logic                       done;

    assign cmd_ready = !pend_full;
    assign accept    = cmd_valid && !pend_full;
    assign PSEL      = (state != ST_IDLE);
    assign PENABLE   = (state == ST_ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // abort on the edge that would bring the wait count to TIMEOUT_CYCLES
    assign abort = (state == ST_ACCESS) && !PREADY && (wait_cnt == WAIT_LAST);
`else
    assign abort = 1'b0;
`endif

    assign done = (state == ST_ACCESS) && (PREADY || abort);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pend_full  <= 1'b0;
            pend_write <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            PADDR      <= '0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= done;
            if (done) begin
                rsp_err   <= PSLVERR || abort;
                rsp_rdata <= (!PWRITE && !PSLVERR && !abort) ? PRDATA : '0;
            end else begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        PADDR  <= cmd_addr;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_write ? cmd_wdata : '0;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                    if (accept) begin
                        pend_full  <= 1'b1;
                        pend_write <= cmd_write;
                        pend_addr  <= cmd_addr;
                        pend_wdata <= cmd_write ? cmd_wdata : '0;
                    end
                end
                ST_ACCESS: begin
                    if (done) begin
                        // a full pending slot blocks cmd_ready, so accept cannot coincide with it
                        if (pend_full) begin
                            PADDR     <= pend_addr;
                            PWRITE    <= pend_write;
                            PWDATA    <= pend_wdata;
                            pend_full <= 1'b0;
                            state     <= ST_SETUP;
                        end else if (accept) begin
                            PADDR  <= cmd_addr;
                            PWRITE <= cmd_write;
                            PWDATA <= cmd_write ? cmd_wdata : '0;
                            state  <= ST_SETUP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (accept) begin
                        pend_full  <= 1'b1;
                        pend_write <= cmd_write;
                        pend_addr  <= cmd_addr;
                        pend_wdata <= cmd_write ? cmd_wdata : '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table, hand sequences (back-to-back, wait limit, reset) and random traffic.
// The APB slave is scripted per command; expected responses come from a transaction-level model.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    localparam int DW = 32;
    localparam int AW = 20;
    localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    apb_master_bridge #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          err;
    } plan_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
        int            acc_cyc;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        logic          err;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    log_en = 1'b0;
    logic [1:0] pe_log[$];
    logic       rdy_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one response per command, latency 3 + wait states.
    function automatic exp_t model(input plan_t p);
        exp_t e;
        e.acc_cyc = 0;
        if (TIMEOUT_ON && p.waits >= TO) begin
            e.err = 1'b1; e.rdata = '0; e.lat = 2 + TO;
        end else begin
            e.err = p.err; e.rdata = (!p.wr && !p.err) ? p.prdata : '0; e.lat = 3 + p.waits;
        end
        return e;
    endfunction

    task automatic send(input plan_t p, input exp_t e_in, input bit use_model, input bit chk_lat);
        exp_t e;
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = p.wr; cmd_addr = p.addr; cmd_wdata = p.wdata;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles", n);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e = use_model ? model(p) : e_in;
        e.acc_cyc = cyc;
        if (!chk_lat) e.lat = 0;
        plan_q.push_back(p);
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || PSEL) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_bus(input plan_t c, input string stage);
        check({stage, "_paddr"}, 64'(PADDR), 64'(c.addr));
        check({stage, "_pwrite"}, 64'(PWRITE), 64'(c.wr));
        check({stage, "_pwdata"}, 64'(PWDATA), 64'(c.wr ? c.wdata : '0));
    endtask

    // scripted APB slave plus per-cycle protocol checks
    initial begin
        plan_t cur;
        int wl = 0;
        bit prev_setup = 1'b0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_setup = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
            end else begin
                if (prev_setup) check("setup_one_cycle", 64'({PSEL, PENABLE}), 64'(2'b11));
                if (PENABLE) check("penable_implies_psel", 64'(PSEL), 64'd1);
                prev_setup = PSEL && !PENABLE;
                if (PSEL && !PENABLE) begin
                    if (plan_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL setup_unexpected: PSEL with no accepted command, PADDR %h", PADDR);
                    end else begin
                        cur = plan_q.pop_front();
                        wl = cur.waits;
                        check_bus(cur, "setup");
                    end
                    PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
                end else if (PSEL && PENABLE) begin
                    if (wl > 0) begin
                        wl--;
                        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
                    end else begin
                        PREADY = 1'b1; PRDATA = cur.prdata; PSLVERR = cur.err;
                        check_bus(cur, "access");
                    end
                end else begin
                    PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_unexpected: rdata %h err %b with no command outstanding", rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (e.lat != 0) check("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (log_en) begin
            pe_log.push_back({PSEL, PENABLE});
            rdy_log.push_back(cmd_ready);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t  vt[6];
    plan_t p;
    exp_t  e0;

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        e0 = '{rdata: '0, err: 1'b0, lat: 0, acc_cyc: 0};
        vt[0] = '{1'b1, 20'h00004, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 3};
        vt[1] = '{1'b0, 20'h00008, 32'hFFFF_0000, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 6};
        vt[2] = '{1'b0, 20'h0000C, 32'h0,         0, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b1, 3};
        vt[3] = '{1'b0, 20'h00000, 32'h5555_5555, 1, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 4};
        vt[4] = '{1'b1, 20'hFFFFC, 32'hFFFF_FFFF, 2, 32'h0BAD_0BAD, 1'b1, 32'h0,         1'b1, 5};
        vt[5] = '{1'b0, 20'h00004, 32'h1,         0, 32'h0,         1'b0, 32'h0,         1'b0, 3};

        repeat (3) @(negedge clk);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        rst = 1'b1;

        foreach (vt[i]) begin
            exp_t e;
            p = '{vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].waits, vt[i].prdata, vt[i].err};
            e = '{rdata: vt[i].exp_rdata, err: vt[i].exp_err, lat: vt[i].exp_lat, acc_cyc: 0};
            send(p, e, 1'b0, 1'b1);
            idle();
            check("vec_setup_phase", 64'({PSEL, PENABLE}), 64'(2'b10));
            @(negedge clk);
            check("vec_access_phase", 64'({PSEL, PENABLE}), 64'(2'b11));
            drain();
        end

        begin
            logic [5:0] pen_bits;
            int n_sel, first_i, last_i, rdy_low;
            pe_log.delete(); rdy_log.delete();
            log_en = 1'b1;
            for (int k = 0; k < 3; k++) begin
                p = '{1'b1, AW'(4 * k), 32'hB2B0_0000 + DW'(k), 0, 32'hFFFF_FFFF, 1'b0};
                send(p, e0, 1'b1, 1'b0);
            end
            idle();
            drain();
            log_en = 1'b0;
            pen_bits = '0; n_sel = 0; first_i = -1; last_i = -1; rdy_low = 0;
            foreach (pe_log[i]) begin
                if (pe_log[i][1]) begin
                    pen_bits = {pen_bits[4:0], pe_log[i][0]};
                    n_sel++;
                    if (first_i < 0) first_i = i;
                    last_i = i;
                end
                if (!rdy_log[i]) rdy_low++;
            end
            check("b2b_psel_cycles", 64'(n_sel), 64'd6);
            check("b2b_psel_contiguous", 64'(last_i - first_i + 1), 64'(n_sel));
            check("b2b_penable_pattern", 64'(pen_bits), 64'(6'b010101));
            check("b2b_ready_low_cycles", 64'(rdy_low), 64'd2);
        end

        p = '{1'b0, 20'h00010, 32'h0, 150, 32'h5A5A_A5A5, 1'b0};
        send(p, e0, 1'b1, 1'b1);
        idle();
`ifdef APB_MASTER_TIMEOUT_EN
        repeat (TO + 1) @(negedge clk);
        check("timeout_rsp_valid", 64'(rsp_valid), 64'd1);
        check("timeout_psel_drop", 64'(PSEL), 64'd0);
`else
        repeat (100) @(negedge clk);
        check("no_timeout_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        check("no_timeout_outstanding", 64'(exp_q.size()), 64'd1);
`endif
        drain();

        for (int k = 0; k < 60; k++) begin
            int gap;
            p.wr = 1'($urandom_range(0, 1));
            p.addr = AW'($urandom);
            p.wdata = $urandom;
            p.waits = $urandom_range(0, 3);
            p.prdata = $urandom;
            p.err = ($urandom_range(0, 7) == 0);
            send(p, e0, 1'b1, 1'b0);
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                idle();
                repeat (gap - 1) @(negedge clk);
            end
        end
        idle();
        drain();

        p = '{1'b0, 20'h00020, 32'h0, 10, 32'h7777_7777, 1'b0};
        send(p, e0, 1'b1, 1'b0);
        p = '{1'b1, 20'h00024, 32'h8888_8888, 0, 32'h0, 1'b0};
        send(p, e0, 1'b1, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        check("pre_reset_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        check("pre_reset_pending_full", 64'(cmd_ready), 64'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_psel", 64'(PSEL), 64'd0);
        check("async_rst_penable", 64'(PENABLE), 64'd0);
        check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("async_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        exp_q.delete();
        plan_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        p = '{1'b1, 20'h00028, 32'h1357_9BDF, 1, 32'hFFFF_FFFF, 1'b0};
        send(p, e0, 1'b1, 1'b1);
        idle();
        drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
